// File: rtl/oops_structs.sv
// Shared OOPs core datapath types: the dispatch/issue instruction element and the
// common-data-bus broadcast record snooped by the scheduling structures.
package oops_structs;

   localparam int OOPS_WIDTH = 32;
   localparam int OOPS_TAG_W = 4;
   localparam int OOPS_PC_W  = 32;
   localparam int OOPS_OP_W  = 8;

   // cb1/cb2 set means val1/val2 still carry a ROB tag in their low OOPS_TAG_W bits.
   typedef struct packed {
      logic [OOPS_PC_W-1:0]  pc;
      logic [OOPS_OP_W-1:0]  opcode;
      logic [OOPS_TAG_W-1:0] rob_tag;
      logic                  cb1;
      logic [OOPS_WIDTH-1:0] val1;
      logic                  cb2;
      logic [OOPS_WIDTH-1:0] val2;
   } instruction_element_t;

   typedef struct packed {
      logic                  vld;
      logic [OOPS_TAG_W-1:0] tag;
      logic [OOPS_WIDTH-1:0] data;
   } cdb_t;

   function automatic logic is_resolved(input instruction_element_t e);
      return !e.cb1 && !e.cb2;
   endfunction

endpackage

// File: rtl/iq_select.sv
// Find-first picker: lowest-index set request gives a one-hot grant, its index and
// an any-valid flag. Index defaults to zero when nothing is requested.
module iq_select #(
   parameter  int DEPTH = 8,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] req_i,
   output logic [DEPTH-1:0] onehot_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   logic found;

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      found    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (req_i[i] && !found) begin
            onehot_o[i] = 1'b1;
            idx_o       = IDX_W'(i);
            found       = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/issue_queue.sv
// Compacting, age-ordered issue queue with CDB wakeup and enqueue bypass.
// IQ_OOO_ISSUE_EN selects oldest-ready issue; undefined gives in-order (head only) issue.
module issue_queue
   import oops_structs::*;
#(
   parameter int WIDTH   = OOPS_WIDTH,
   parameter int DEPTH   = 8,
   parameter int TAG_W   = OOPS_TAG_W,
   parameter int NUM_CDB = 2,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       vld_i,
   output logic                       rdy_i,
   input  instruction_element_t       instruction_i,
   input  cdb_t [NUM_CDB-1:0]         cdb_i,
   output logic                       vld_o,
   input  logic                       rdy_o,
   output instruction_element_t       instruction_o,
   output logic [CNT_W-1:0]           count_o
);

   instruction_element_t slot_q [DEPTH];
   instruction_element_t slot_d [DEPTH];
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_d;

   logic [DEPTH-1:0]     ready_vec;
   logic [DEPTH-1:0]     sel_onehot;
   logic [IDX_W-1:0]     sel_idx;
   logic                 sel_any;
   logic                 issue;
   logic                 enq;
   logic [CNT_W-1:0]     live;
   instruction_element_t sel_entry;

   // Lowest channel wins on duplicate tags: once an operand clears its CB flag,
   // later channels no longer match it.
   function automatic instruction_element_t wake(input instruction_element_t e,
                                                 input cdb_t [NUM_CDB-1:0] cdb);
      instruction_element_t r;
      r = e;
      for (int k = 0; k < NUM_CDB; k++) begin
         if (cdb[k].vld && r.cb1 && (cdb[k].tag == e.val1[TAG_W-1:0])) begin
            r.val1 = cdb[k].data[WIDTH-1:0];
            r.cb1  = 1'b0;
         end
         if (cdb[k].vld && r.cb2 && (cdb[k].tag == e.val2[TAG_W-1:0])) begin
            r.val2 = cdb[k].data[WIDTH-1:0];
            r.cb2  = 1'b0;
         end
      end
      return r;
   endfunction

   always_comb begin
      ready_vec = '0;
`ifdef IQ_OOO_ISSUE_EN
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = (CNT_W'(i) < count_q) && is_resolved(slot_q[i]);
      end
`else
      ready_vec[0] = (count_q != '0) && is_resolved(slot_q[0]);
`endif
   end

   iq_select #(
      .DEPTH (DEPTH)
   ) u_select (
      .req_i    (ready_vec),
      .onehot_o (sel_onehot),
      .idx_o    (sel_idx),
      .any_o    (sel_any)
   );

   always_comb begin
      sel_entry = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel_onehot[i]) begin
            sel_entry = instruction_element_t'(sel_entry | slot_q[i]);
         end
      end
   end

   // With nothing ready the head is shown, so an empty queue exposes slot 0's stale data.
   assign instruction_o = sel_any ? sel_entry : slot_q[0];
   assign vld_o         = sel_any;
   assign rdy_i         = count_q < CNT_W'(DEPTH);
   assign count_o       = count_q;

   assign issue = vld_o && rdy_o;
   assign enq   = vld_i && rdy_i;
   assign live  = count_q - CNT_W'(issue);

   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue && (IDX_W'(i) >= sel_idx)) begin
               slot_d[i] = slot_q[i + 1];
            end
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < live) begin
               slot_d[i] = wake(slot_d[i], cdb_i);
            end
         end
         // New entry lands just above the surviving entries, catching same-cycle broadcasts.
         for (int i = 0; i < DEPTH; i++) begin
            if (enq && (CNT_W'(i) == live)) begin
               slot_d[i] = wake(instruction_i, cdb_i);
            end
         end
         count_d = live + CNT_W'(enq);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   a_issue_resolved : assert property (@(posedge clk) disable iff (rst)
      vld_o |-> (!instruction_o.cb1 && !instruction_o.cb2));

   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_issue_queue.sv
// Directed scenarios plus a randomized run against a queue-based reference model
// of the issue queue (age order, wakeup, bypass, select, flush).
module tb_issue_queue;
   import oops_structs::*;

   localparam int DEPTH   = 8;
   localparam int NUM_CDB = 2;
   localparam int WIDTH   = 32;
   localparam int TAG_W   = 4;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic                 vld_i;
   logic                 rdy_i;
   instruction_element_t instruction_i;
   cdb_t [NUM_CDB-1:0]   cdb_i;
   logic                 vld_o;
   logic                 rdy_o;
   instruction_element_t instruction_o;
   logic [CNT_W-1:0]     count_o;

   int total = 0;
   int bad   = 0;

   instruction_element_t model_q[$];

   issue_queue #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W),
      .NUM_CDB (NUM_CDB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .vld_i         (vld_i),
      .rdy_i         (rdy_i),
      .instruction_i (instruction_i),
      .cdb_i         (cdb_i),
      .vld_o         (vld_o),
      .rdy_o         (rdy_o),
      .instruction_o (instruction_o),
      .count_o       (count_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic instruction_element_t mk(input logic cb1, input logic [31:0] v1,
                                               input logic cb2, input logic [31:0] v2,
                                               input logic [31:0] pc);
      instruction_element_t e;
      e = '0;
      e.cb1 = cb1; e.val1 = v1; e.cb2 = cb2; e.val2 = v2; e.pc = pc;
      return e;
   endfunction

   // Reference wakeup: a pending operand takes data from the first channel carrying its tag.
   function automatic instruction_element_t ref_wake(input instruction_element_t e,
                                                     input cdb_t [NUM_CDB-1:0] cdb);
      instruction_element_t r;
      r = e;
      if (e.cb1) begin
         for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb[k].vld && cdb[k].tag == e.val1[TAG_W-1:0]) begin
               r.val1 = cdb[k].data; r.cb1 = 1'b0; break;
            end
         end
      end
      if (e.cb2) begin
         for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb[k].vld && cdb[k].tag == e.val2[TAG_W-1:0]) begin
               r.val2 = cdb[k].data; r.cb2 = 1'b0; break;
            end
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      vld_i = 1'b0; rdy_o = 1'b0; flush = 1'b0; cdb_i = '0; instruction_i = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input instruction_element_t e);
      vld_i = 1'b1; instruction_i = e;
      tick();
      vld_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
      total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL reset_vld_o: got %b want 0", vld_o); end
      total++; if (rdy_i !== 1'b1) begin bad++; $display("FAIL reset_rdy_i: got %b want 1", rdy_i); end
      total++; if (instruction_o !== '0) begin bad++; $display("FAIL reset_instr: got %h want 0", instruction_o); end
   endtask

   task automatic test_basic();
      do_reset();
      rdy_o = 1'b1;
      push(mk(1'b0, 32'd2, 1'b0, 32'd1, 32'h60));
      total++; if (vld_o !== 1'b1) begin bad++; $display("FAIL basic_vld: got %b want 1", vld_o); end
      total++; if (instruction_o.pc !== 32'h60) begin bad++; $display("FAIL basic_pc: got %h want 60", instruction_o.pc); end
      total++; if (instruction_o.val1 !== 32'd2) begin bad++; $display("FAIL basic_val1: got %h want 2", instruction_o.val1); end
      tick();
      total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL basic_vld_after: got %b want 0", vld_o); end
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL basic_count_after: got %0d want 0", count_o); end
      idle();
   endtask

   task automatic test_wakeup();
      do_reset();
      push(mk(1'b1, 32'd2, 1'b0, 32'd7, 32'hA0));
      push(mk(1'b0, 32'd3, 1'b0, 32'd4, 32'hB0));
      total++; if (count_o !== 4'd2) begin bad++; $display("FAIL wake_count2: got %0d want 2", count_o); end
`ifdef IQ_OOO_ISSUE_EN
      total++; if (vld_o !== 1'b1) begin bad++; $display("FAIL wake_ooo_vld: got %b want 1", vld_o); end
      total++; if (instruction_o.pc !== 32'hB0) begin bad++; $display("FAIL wake_ooo_pc_b: got %h want b0", instruction_o.pc); end
      rdy_o = 1'b1;
      tick();
      total++; if (count_o !== 4'd1) begin bad++; $display("FAIL wake_ooo_count1: got %0d want 1", count_o); end
      total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL wake_ooo_pending: got %b want 0", vld_o); end
      rdy_o = 1'b0;
      cdb_i[0] = '{vld: 1'b1, tag: 4'd2, data: 32'hDEADBEEF};
      tick();
      cdb_i = '0;
      total++; if (vld_o !== 1'b1) begin bad++; $display("FAIL wake_vld_a: got %b want 1", vld_o); end
      total++; if (instruction_o.pc !== 32'hA0) begin bad++; $display("FAIL wake_pc_a: got %h want a0", instruction_o.pc); end
      total++; if (instruction_o.val1 !== 32'hDEADBEEF) begin bad++; $display("FAIL wake_val1: got %h want deadbeef", instruction_o.val1); end
      total++; if (instruction_o.cb1 !== 1'b0) begin bad++; $display("FAIL wake_cb1: got %b want 0", instruction_o.cb1); end
      rdy_o = 1'b1;
      tick();
`else
      total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL wake_ino_blocked: got %b want 0", vld_o); end
      rdy_o = 1'b1;
      tick();
      total++; if (count_o !== 4'd2) begin bad++; $display("FAIL wake_ino_hold: got %0d want 2", count_o); end
      cdb_i[0] = '{vld: 1'b1, tag: 4'd2, data: 32'hDEADBEEF};
      tick();
      cdb_i = '0;
      total++; if (vld_o !== 1'b1) begin bad++; $display("FAIL wake_vld_a: got %b want 1", vld_o); end
      total++; if (instruction_o.pc !== 32'hA0) begin bad++; $display("FAIL wake_pc_a: got %h want a0", instruction_o.pc); end
      total++; if (instruction_o.val1 !== 32'hDEADBEEF) begin bad++; $display("FAIL wake_val1: got %h want deadbeef", instruction_o.val1); end
      total++; if (instruction_o.cb1 !== 1'b0) begin bad++; $display("FAIL wake_cb1: got %b want 0", instruction_o.cb1); end
      tick();
      total++; if (instruction_o.pc !== 32'hB0) begin bad++; $display("FAIL wake_ino_pc_b: got %h want b0", instruction_o.pc); end
      tick();
`endif
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL wake_drained: got %0d want 0", count_o); end
      idle();
   endtask

   task automatic test_bypass();
      do_reset();
      cdb_i[1] = '{vld: 1'b1, tag: 4'd5, data: 32'h0E};
      push(mk(1'b0, 32'd1, 1'b1, 32'd5, 32'hC0));
      cdb_i = '0;
      total++; if (vld_o !== 1'b1) begin bad++; $display("FAIL bypass_vld: got %b want 1", vld_o); end
      total++; if (instruction_o.val2 !== 32'h0E) begin bad++; $display("FAIL bypass_val2: got %h want e", instruction_o.val2); end
      total++; if (instruction_o.cb2 !== 1'b0) begin bad++; $display("FAIL bypass_cb2: got %b want 0", instruction_o.cb2); end
      cdb_i[0] = '{vld: 1'b1, tag: 4'd6, data: 32'h111};
      cdb_i[1] = '{vld: 1'b1, tag: 4'd6, data: 32'h222};
      push(mk(1'b1, 32'd6, 1'b0, 32'd0, 32'hC1));
      cdb_i = '0;
      rdy_o = 1'b1;
      tick();
      total++; if (instruction_o.pc !== 32'hC1) begin bad++; $display("FAIL bypass_pc2: got %h want c1", instruction_o.pc); end
      total++; if (instruction_o.val1 !== 32'h111) begin bad++; $display("FAIL bypass_lowest_k: got %h want 111", instruction_o.val1); end
      tick();
      idle();
   endtask

   task automatic test_full();
      do_reset();
      for (int j = 0; j < DEPTH; j++) push(mk(1'b0, 32'(j), 1'b0, 32'd0, 32'(j)));
      total++; if (count_o !== 4'd8) begin bad++; $display("FAIL full_count: got %0d want 8", count_o); end
      total++; if (rdy_i !== 1'b0) begin bad++; $display("FAIL full_rdy_i: got %b want 0", rdy_i); end
      vld_i = 1'b1; instruction_i = mk(1'b0, 32'd9, 1'b0, 32'd9, 32'h99); rdy_o = 1'b1;
      tick();
      vld_i = 1'b0;
      total++; if (count_o !== 4'd7) begin bad++; $display("FAIL full_count_after: got %0d want 7", count_o); end
      total++; if (rdy_i !== 1'b1) begin bad++; $display("FAIL full_rdy_after: got %b want 1", rdy_i); end
      for (int j = 1; j < DEPTH; j++) begin
         total++; if (instruction_o.pc !== 32'(j)) begin bad++; $display("FAIL full_drain_pc: got %h want %h", instruction_o.pc, j); end
         tick();
      end
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", count_o); end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      for (int j = 0; j < 3; j++) push(mk(1'b0, 32'd0, 1'b0, 32'd0, 32'h40 + 32'(j)));
      flush = 1'b1; vld_i = 1'b1; rdy_o = 1'b1; instruction_i = mk(1'b0, 32'd0, 1'b0, 32'd0, 32'h77);
      tick();
      idle();
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count_o); end
      total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL flush_vld: got %b want 0", vld_o); end
      push(mk(1'b0, 32'd0, 1'b0, 32'd0, 32'h55));
      total++; if (count_o !== 4'd1) begin bad++; $display("FAIL flush_refill_count: got %0d want 1", count_o); end
      total++; if (instruction_o.pc !== 32'h55) begin bad++; $display("FAIL flush_refill_pc: got %h want 55", instruction_o.pc); end
   endtask

   task automatic test_rst_mid();
      do_reset();
      for (int j = 0; j < 4; j++) push(mk(1'b0, 32'd3, 1'b1, 32'd1, 32'h80 + 32'(j)));
      total++; if (count_o !== 4'd4) begin bad++; $display("FAIL rstmid_pre: got %0d want 4", count_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count_o); end
      total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL rstmid_vld: got %b want 0", vld_o); end
      total++; if (rdy_i !== 1'b1) begin bad++; $display("FAIL rstmid_rdy: got %b want 1", rdy_i); end
      total++; if (instruction_o !== '0) begin bad++; $display("FAIL rstmid_instr: got %h want 0", instruction_o); end
   endtask

   task automatic test_random();
      instruction_element_t e;
      int  sel;
      bit  exp_vld, exp_rdy_i;
      do_reset();
      model_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         e = '0;
         e.pc = $urandom; e.opcode = 8'($urandom); e.rob_tag = 4'($urandom);
         e.cb1 = ($urandom_range(0, 1) == 1); e.val1 = $urandom;
         e.cb2 = ($urandom_range(0, 2) == 0); e.val2 = $urandom;
         instruction_i = e;
         vld_i = ($urandom_range(0, 9) < 6);
         rdy_o = ($urandom_range(0, 9) < ((cyc % 400) < 200 ? 7 : 3));
         flush = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < NUM_CDB; k++) begin
            cdb_i[k].vld  = ($urandom_range(0, 1) == 1);
            cdb_i[k].tag  = 4'($urandom);
            cdb_i[k].data = $urandom;
         end
         sel = -1;
`ifdef IQ_OOO_ISSUE_EN
         foreach (model_q[i]) if (sel < 0 && !model_q[i].cb1 && !model_q[i].cb2) sel = i;
`else
         if (model_q.size() > 0 && !model_q[0].cb1 && !model_q[0].cb2) sel = 0;
`endif
         exp_vld   = (sel >= 0);
         exp_rdy_i = (model_q.size() < DEPTH);
         total++; if (count_o !== CNT_W'(model_q.size())) begin bad++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, count_o, model_q.size()); end
         total++; if (rdy_i !== exp_rdy_i) begin bad++; $display("FAIL rand_rdy_i cyc %0d: got %b want %b", cyc, rdy_i, exp_rdy_i); end
         total++; if (vld_o !== exp_vld) begin bad++; $display("FAIL rand_vld_o cyc %0d: got %b want %b", cyc, vld_o, exp_vld); end
         if (exp_vld) begin
            total++; if (instruction_o !== model_q[sel]) begin bad++; $display("FAIL rand_instr cyc %0d: got %h want %h", cyc, instruction_o, model_q[sel]); end
         end
         if (flush) begin
            model_q.delete();
         end else begin
            if (exp_vld && rdy_o) model_q.delete(sel);
            foreach (model_q[i]) model_q[i] = ref_wake(model_q[i], cdb_i);
            if (vld_i && exp_rdy_i) model_q.push_back(ref_wake(instruction_i, cdb_i));
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_basic();
      test_wakeup();
      test_bypass();
      test_full();
      test_flush();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised out-of-order issue queue for the OOPs core. It sits between dispatch and the functional units and holds up to DEPTH `instruction_element_t` entries whose operands may still be pending on ROB tags. It snoops NUM_CDB common-data-bus channels to wake up pending operands. Each cycle it issues the oldest entry whose operands are both resolved.

## Interface
Parameters:
- WIDTH, 32, operand data width
- DEPTH, 8, entry count (power of two not required, ≥2)
- TAG_W, 4, ROB tag width; a pending operand's tag sits in val[TAG_W-1:0]
- NUM_CDB, 2, broadcast channels snooped per cycle

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all entries
- vld_i  in  1  dispatch offers instruction_i
- rdy_i  out  1  queue can accept (count < DEPTH)
- instruction_i  in  instruction_element_t  incoming entry; CB1/CB2=1 means val1/val2 hold a tag
- cdb_i  in  cdb_t [NUM_CDB]  per channel: vld, tag[TAG_W], data[WIDTH]
- vld_o  out  1  instruction_o is issuable
- rdy_o  in  1  functional unit accepts instruction_o
- instruction_o  out  instruction_element_t  selected entry, CB1=CB2=0 guaranteed when vld_o
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: compacting, age-ordered array; slot 0 is oldest, valid slots are 0..count-1.
- Enqueue: fires when vld_i && rdy_i. The entry is written to slot count, or to slot count-1 if an issue also fires that cycle.
- Wakeup: for each valid entry and each operand with CB=1, if any cdb_i[k].vld and cdb_i[k].tag == val[TAG_W-1:0], then val←data and CB←0. The lowest k wins on duplicate tags.
- Enqueue bypass: wakeup also applies to instruction_i in the cycle it is enqueued.
- Select: the ready set is entries with CB1=0 and CB2=0, using registered flags only. instruction_o is the lowest-index ready entry; vld_o = ready set non-empty.
- Issue: fires when vld_o && rdy_o. The selected slot is removed and younger slots shift down by one. Wakeup applies to the shifted data.
- rdy_i depends on count only, not on same-cycle issue (no combinational rdy_o→rdy_i path).
- Priority: rst > flush > {issue, enqueue, wakeup}.
  - flush: count←0 and vld_o=0 next cycle; same-cycle enqueue and issue are dropped.
- Full (count==DEPTH): rdy_i=0, and an enqueue cannot fire even if an issue fires that cycle.
- Empty: vld_o=0, and instruction_o is slot 0's stale contents.
- Reset values: count_o=0, vld_o=0, rdy_i=1, all slots zeroed (instruction_o all zeros).

## Timing
- Enqueue of a fully resolved entry at edge N: vld_o=1 in cycle N+1 (1-cycle latency).
- Broadcast in cycle N wakes an entry; it is issuable from cycle N+1.
- An issued entry disappears at the issuing edge; the next ready entry is presented in the following cycle.
- instruction_o and vld_o are combinational from registered state only.
- Sustained throughput: one enqueue and one issue per cycle.

## Configuration
- IQ_OOO_ISSUE_EN defined: select is the oldest ready entry anywhere in the queue (as above).
- IQ_OOO_ISSUE_EN undefined: in-order mode. Only slot 0 may issue; vld_o = count>0 && slot0 CB1=0 && CB2=0. Wakeup and bypass are unchanged.

## Structure
- `oops_structs` gets `cdb_t` (vld, tag, data). `instruction_element_t` stays there unchanged.
- Sub-module `iq_select`: DEPTH-wide ready vector in, find-first one-hot plus index plus any-valid out; parametrised on DEPTH.
- Compaction, enqueue, and wakeup stay in `issue_queue`.

## Test plan
- Reset, then enqueue {CB1=0,val1=2,CB2=0,val2=1,pc=0x60} with rdy_o=1 → vld_o=1 next cycle, instruction_o.pc=0x60; after the issue edge, vld_o=0 and count_o=0.
- Enqueue A {CB1=1,val1=tag 2} then B resolved → OOO build issues B first. With cdb_i[0]={1,2,0xDEADBEEF}, A issues with val1=0xDEADBEEF, CB1=0. In-order build: nothing issues until the broadcast, then A then B.
- Enqueue {CB2=1,val2=tag 5} in the same cycle cdb_i[1] broadcasts tag 5, data 0x0E → entry stored with val2=0x0E, CB2=0, vld_o=1 next cycle.
- Fill 8 resolved entries with rdy_o=0 → count_o=8, rdy_i=0. A vld_i with rdy_o=1 that cycle → one issue, no enqueue, count_o=7, rdy_i=1.
- Queue holds 3 entries; assert flush with vld_i=1 and rdy_o=1 → next cycle count_o=0, vld_o=0, no issue was accepted.
- Assert rst mid-operation with 4 entries → next cycle count_o=0, vld_o=0, rdy_i=1, instruction_o=0.
